// File: rtl/path_ro_counter_pkg.sv
// ============================================================================
// path_ro_counter_pkg : shared FSM encoding and sizing helper
// Rev 1.0
// ============================================================================
`default_nettype none

package path_ro_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Index width that stays at least one bit even for a count of one.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/path_sync_ff.sv
// ============================================================================
// path_sync_ff : multi-flop synchronizer for the asynchronous ring output
// Rev 1.0
// ============================================================================
`default_nettype none

module path_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    (* ASYNC_REG = "TRUE", keep = "true" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/path_ro_counter.sv
// ============================================================================
// path_ro_counter : ring-oscillator edge counter over fixed clock windows,
//                   accumulated and compared against a golden band
// Rev 1.0
// ============================================================================
`default_nettype none

module path_ro_counter
    import path_ro_counter_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1024,
    parameter int NUM_WIN       = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 16,
    parameter int ACC_W         = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] lo_thresh,
    input  logic [ACC_W-1:0] hi_thresh,
    input  logic             ro_in,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic             alarm,
    output logic             overflow
);

    localparam int CYC_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = clog2_min1(CYC_MAX);
    localparam int IDX_W   = clog2_min1(NUM_WIN);

    state_t             r_state;
    state_t             w_next;
    logic [CYC_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_win_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]   r_win_idx;
    logic               r_ovf_int;
    logic               r_sync_prev;
    logic               r_ro_en;
    logic               r_busy;
    logic               r_done;
    logic [ACC_W-1:0]   r_result;
    logic               r_alarm;
    logic               r_overflow;

    logic               w_sync_q;
    logic               w_edge;
    logic               w_settle_end;
    logic               w_win_end;
    logic               w_last_win;
    logic               w_cnt_sat;
    logic               w_cnt_lost;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [ACC_W:0]     w_sum;
    logic               w_acc_sat;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_final_ovf;

    path_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (ro_in),
        .o_sync  (w_sync_q)
    );

    assign w_edge       = w_sync_q & ~r_sync_prev;
    assign w_settle_end = (r_state == ST_SETTLE) && (r_cyc == CYC_W'(SETTLE_CYCLES - 1));
    assign w_win_end    = (r_state == ST_COUNT) && (r_cyc == CYC_W'(WINDOW_CYCLES - 1));
    assign w_last_win   = (r_win_idx == IDX_W'(NUM_WIN - 1));

    // An edge arriving while the window counter is pinned is a lost count.
    assign w_cnt_sat    = &r_win_cnt;
    assign w_cnt_lost   = w_edge & w_cnt_sat;
    assign w_cnt_inc    = (w_edge && !w_cnt_sat) ? r_win_cnt + CNT_W'(1) : r_win_cnt;

    assign w_sum        = {1'b0, r_acc} + {{(ACC_W + 1 - CNT_W){1'b0}}, w_cnt_inc};
    assign w_acc_sat    = w_sum[ACC_W];
    assign w_acc_next   = w_acc_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_final_ovf  = r_ovf_int | w_cnt_lost | w_acc_sat;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_SETTLE;
            ST_SETTLE: if (w_settle_end) w_next = ST_COUNT;
            ST_COUNT:  if (w_win_end && w_last_win) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc       <= '0;
            r_win_cnt   <= '0;
            r_acc       <= '0;
            r_win_idx   <= '0;
            r_ovf_int   <= 1'b0;
            r_sync_prev <= 1'b0;
            r_ro_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_alarm     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            // Edge history runs in every state so COUNT never sees a stale edge.
            r_sync_prev <= w_sync_q;
            r_ro_en     <= (w_next == ST_SETTLE) || (w_next == ST_COUNT);
            r_busy      <= (w_next != ST_IDLE);
            r_done      <= (w_next == ST_DONE);

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cyc     <= '0;
                        r_win_cnt <= '0;
                        r_acc     <= '0;
                        r_win_idx <= '0;
                        r_ovf_int <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    r_cyc <= w_settle_end ? '0 : r_cyc + CYC_W'(1);
                end
                ST_COUNT: begin
                    if (w_win_end) begin
                        r_cyc     <= '0;
                        r_win_cnt <= '0;
                        r_acc     <= w_acc_next;
                        r_ovf_int <= w_final_ovf;
                        r_win_idx <= r_win_idx + IDX_W'(1);
                        if (w_last_win) begin
                            r_result   <= w_acc_next;
                            r_alarm    <= (w_acc_next < lo_thresh) || (w_acc_next > hi_thresh);
                            r_overflow <= w_final_ovf;
                        end
                    end else begin
                        r_cyc     <= r_cyc + CYC_W'(1);
                        r_win_cnt <= w_cnt_inc;
                        r_ovf_int <= r_ovf_int | w_cnt_lost;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ro_en    = r_ro_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign alarm    = r_alarm;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_path_ro_counter.sv
// ============================================================================
// tb_path_ro_counter : directed and randomized checks of path_ro_counter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_path_ro_counter;

    localparam int WIN    = 64;
    localparam int NWIN   = 4;
    localparam int SETTLE = 16;
    localparam int SYNC   = 2;
    localparam int ACCW   = 10;
    localparam int HSZ    = 32768;
    localparam int LAT    = 1 + SETTLE + NWIN * WIN;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [ACCW-1:0] lo_thresh;
    logic [ACCW-1:0] hi_thresh;
    logic            ro_in;

    logic            ro_en, busy, done, alarm, overflow;
    logic [ACCW-1:0] result;
    logic            s_ro_en, s_busy, s_done, s_alarm, s_overflow;
    logic [ACCW-1:0] s_result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit hist [0:HSZ-1];

    int mode = 0, lvl = 0, per = 8, hlen = 4, phase = 0, dens = 50;

    int m_done_at, m_done_cnt, m_busy_cnt, m_ro_cnt, m_sro_cnt, m_gap, m_hold, m_prev;
    int m_res, m_alarm, m_ovf, s_res, s_alm, s_ovf, s_done_ok, m_k;

    path_ro_counter #(
        .WINDOW_CYCLES (WIN), .NUM_WIN (NWIN), .SETTLE_CYCLES (SETTLE),
        .SYNC_STAGES (SYNC), .CNT_W (8), .ACC_W (ACCW)
    ) u_dut (
        .clk (clk), .rst (rst), .start (start), .lo_thresh (lo_thresh),
        .hi_thresh (hi_thresh), .ro_in (ro_in), .ro_en (ro_en), .busy (busy),
        .done (done), .result (result), .alarm (alarm), .overflow (overflow)
    );

    path_ro_counter #(
        .WINDOW_CYCLES (WIN), .NUM_WIN (NWIN), .SETTLE_CYCLES (SETTLE),
        .SYNC_STAGES (SYNC), .CNT_W (4), .ACC_W (ACCW)
    ) u_dut_sat (
        .clk (clk), .rst (rst), .start (start), .lo_thresh (lo_thresh),
        .hi_thresh (hi_thresh), .ro_in (ro_in), .ro_en (s_ro_en), .busy (s_busy),
        .done (s_done), .result (s_result), .alarm (s_alarm), .overflow (s_overflow)
    );

    always #5 clk = ~clk;

    // hist[e] is the ring level present at clock edge number e.
    always @(posedge clk) begin
        if (cyc < HSZ) hist[cyc] <= ro_in;
        cyc <= cyc + 1;
    end

    initial begin
        ro_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       ro_in = (lvl != 0);
                1:       ro_in = ((((cyc - phase) % per) + per) % per) < hlen;
                default: ro_in = ($urandom_range(0, 99) < dens);
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count ring rising edges inside each window, saturate per window and in total.
    function automatic void model(input int k, input int cw, output int res, output int ovf);
        int base, c, cmax, amax;
        cmax = (1 << cw) - 1;
        amax = (1 << ACCW) - 1;
        res  = 0;
        ovf  = 0;
        base = k + 1 + SETTLE - SYNC;
        for (int w = 0; w < NWIN; w++) begin
            c = 0;
            for (int j = base + w * WIN; j < base + (w + 1) * WIN; j++)
                if (hist[j] && !hist[j-1]) c++;
            if (c > cmax) begin c = cmax; ovf = 1; end
            res += c;
            if (res > amax) begin res = amax; ovf = 1; end
        end
    endfunction

    task automatic run_meas(input bit spam);
        m_k = cyc;
        m_done_at = -1; m_done_cnt = 0; m_busy_cnt = 0; m_ro_cnt = 0; m_sro_cnt = 0;
        m_gap = 0; m_prev = int'(result); s_done_ok = 0;
        start = 1'b1;
        for (int i = 0; i < LAT + 27; i++) begin
            @(posedge clk);
            #1;
            if (ro_en)   m_ro_cnt++;
            if (s_ro_en) m_sro_cnt++;
            if (busy)    m_busy_cnt++;
            if (!busy && m_done_at < 0) m_gap = 1;
            if (i == 4) m_hold = int'(result);
            if (done) begin
                m_done_cnt++;
                if (m_done_at < 0) begin
                    m_done_at = cyc - m_k;
                    m_res = int'(result); m_alarm = int'(alarm); m_ovf = int'(overflow);
                    s_res = int'(s_result); s_alm = int'(s_alarm); s_ovf = int'(s_overflow);
                    s_done_ok = int'(s_done & s_busy);
                end
            end
            if (spam) start = (m_done_at < 0) ? 1'($urandom_range(0, 1)) : (cyc - m_k == m_done_at);
            else      start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic set_periodic(input int p, input int h, input int ph);
        mode = 1; per = p; hlen = h; phase = ph;
        repeat (6) @(posedge clk);
        #1;
    endtask

    int e_res, e_ovf, e4_res, e4_ovf, kp, lo, hi;

    initial begin
        rst = 1'b1; start = 1'b0; lo_thresh = '0; hi_thresh = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ro_en", ro_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_alarm_ovf", {alarm, overflow}, 0);
        rst = 1'b0;

        // Nominal: period-8 ring, in band.
        lo_thresh = 10'd30; hi_thresh = 10'd34;
        set_periodic(8, 4, 3);
        run_meas(1'b0);
        model(m_k, 8, e_res, e_ovf);
        check("nom_latency", m_done_at, LAT);
        check("nom_done_cnt", m_done_cnt, 1);
        check("nom_result", m_res, 32);
        check("nom_model", m_res, e_res);
        check("nom_alarm", m_alarm, 0);
        check("nom_ovf", m_ovf, 0);
        check("nom_busy_cnt", m_busy_cnt, LAT);

        // Stuck ring.
        mode = 0; lvl = 0; lo_thresh = 10'd1;
        repeat (6) @(posedge clk);
        #1;
        run_meas(1'b0);
        check("stuck_hold", m_hold, m_prev);
        check("stuck_result", m_res, 0);
        check("stuck_alarm", m_alarm, 1);
        check("stuck_ovf", m_ovf, 0);
        check("stuck_ro_en_cycles", m_ro_cnt, SETTLE + NWIN * WIN);

        // Fast ring saturates the 4-bit window counter.
        lo_thresh = 10'd0; hi_thresh = 10'd1023;
        set_periodic(2, 1, 0);
        run_meas(1'b0);
        check("fast_result_w8", m_res, 128);
        check("fast_ovf_w8", m_ovf, 0);
        check("fast_result_w4", s_res, 60);
        check("fast_ovf_w4", s_ovf, 1);
        check("fast_done_w4", s_done_ok, 1);
        check("fast_ro_en_w4", m_sro_cnt, SETTLE + NWIN * WIN);

        // start hammered while busy and on the done cycle.
        lo_thresh = 10'd30; hi_thresh = 10'd34;
        set_periodic(8, 4, 5);
        run_meas(1'b1);
        check("spam_done_cnt", m_done_cnt, 1);
        check("spam_busy_gap", m_gap, 0);
        check("spam_busy_cnt", m_busy_cnt, LAT);
        check("spam_ro_en_cycles", m_ro_cnt, SETTLE + NWIN * WIN);
        check("spam_result", m_res, 32);

        // Reset in the middle of window 2.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (SETTLE + 2 * WIN + 10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ro_en", ro_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        check("midrst_done_ovf", {done, overflow}, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        run_meas(1'b0);
        check("after_rst_result", m_res, 32);
        check("after_rst_latency", m_done_at, LAT);

        // Ring rising edge lands on the last counted cycle of window 0.
        mode = 1; per = 8; hlen = 4;
        kp = cyc + 10;
        phase = (kp + SETTLE - SYNC + WIN) % 8;
        repeat (10) @(posedge clk);
        #1;
        run_meas(1'b0);
        model(m_k, 8, e_res, e_ovf);
        check("align_start", m_k, kp);
        check("align_result", m_res, 32);
        check("align_model", m_res, e_res);

        // Randomized rings and thresholds.
        for (int r = 0; r < 8; r++) begin
            lo = $urandom_range(0, 200);
            hi = $urandom_range(0, 300);
            lo_thresh = lo[ACCW-1:0];
            hi_thresh = hi[ACCW-1:0];
            case ($urandom_range(0, 2))
                0: begin mode = 0; lvl = $urandom_range(0, 1); end
                1: begin per = $urandom_range(2, 16); hlen = $urandom_range(1, per - 1);
                         phase = $urandom_range(0, 15); mode = 1; end
                default: begin dens = $urandom_range(10, 90); mode = 2; end
            endcase
            repeat (6) @(posedge clk);
            #1;
            run_meas(1'b0);
            model(m_k, 8, e_res, e_ovf);
            model(m_k, 4, e4_res, e4_ovf);
            check("rnd_latency", m_done_at, LAT);
            check("rnd_result", m_res, e_res);
            check("rnd_ovf", m_ovf, e_ovf);
            check("rnd_alarm", m_alarm, int'((e_res < lo) || (e_res > hi)));
            check("rnd_result_w4", s_res, e4_res);
            check("rnd_ovf_w4", s_ovf, e4_ovf);
            check("rnd_alarm_w4", s_alm, int'((e4_res < lo) || (e4_res > hi)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
